// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: merges EX branch redirects and MEM exception redirects
// into one load-PC request for fetch, holding a request across stalls until
// fetch can take it. Also drives the IF/ID flush.
//
// Optional feature macro: REDIRECT_STATS_EN
//   defined     -> o_branch_redirects / o_exc_redirects are live 32-bit counters
//   not defined -> both ports are tied to 32'h0 and no counter flops exist
//
// Handshake: a redirect is offered whenever o_load_we=1; fetch takes it in the
// first cycle with i_stall=0 (the accept cycle), which is the only cycle that
// o_flush=1. While stalled, o_load_pc stays stable until accepted.
module pc_redirect_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_br_valid,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_exc_req,
    output logic        o_load_we,
    output logic [31:0] o_load_pc,
    output logic        o_flush,
    output logic        o_misaligned,
    output logic [31:0] o_branch_redirects,
    output logic [31:0] o_exc_redirects
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_BR  = 2'd1,
        HOLD_EXC = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] held_pc;
    logic        held_mis;

    logic        br_req;
    logic        sel_we;
    logic        sel_exc;
    logic [31:0] sel_pc;
    logic        sel_mis;
    logic        accept;

    assign br_req = i_br_valid & i_br_taken;

    // Pick the winning source: new exception, then held request, then new branch.
    always_comb begin
        sel_we  = 1'b0;
        sel_exc = 1'b0;
        sel_pc  = 32'h0;
        sel_mis = 1'b0;
        case (state)
            IDLE: begin
                if (i_exc_req) begin
                    sel_we  = 1'b1;
                    sel_exc = 1'b1;
                    sel_pc  = EXC_VECTOR;
                end else if (br_req) begin
                    sel_we  = 1'b1;
                    sel_pc  = {i_br_target[31:2], 2'b00};
                    sel_mis = |i_br_target[1:0];
                end
            end
            HOLD_BR: begin
                sel_we = 1'b1;
                if (i_exc_req) begin
                    // An older instruction faulted: the held branch is squashed.
                    sel_exc = 1'b1;
                    sel_pc  = EXC_VECTOR;
                end else begin
                    sel_pc  = held_pc;
                    sel_mis = held_mis;
                end
            end
            HOLD_EXC: begin
                // Anything arriving now is younger than the held exception.
                sel_we  = 1'b1;
                sel_exc = 1'b1;
                sel_pc  = EXC_VECTOR;
            end
            default: begin
                sel_we = 1'b0;
            end
        endcase
    end

    assign accept = sel_we & ~i_stall;

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        o_load_we    = rst_n & sel_we;
        o_load_pc    = rst_n ? sel_pc : 32'h0;
        o_flush      = rst_n & accept;
        o_misaligned = rst_n & accept & ~sel_exc & sel_mis;
    end

    // Hold an offered-but-stalled redirect; return to IDLE once fetch accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            held_pc  <= 32'h0;
            held_mis <= 1'b0;
        end else if (sel_we && i_stall) begin
            state    <= sel_exc ? HOLD_EXC : HOLD_BR;
            held_pc  <= sel_pc;
            held_mis <= sel_mis;
        end else begin
            state    <= IDLE;
        end
    end

`ifdef REDIRECT_STATS_EN
    logic [31:0] br_count;
    logic [31:0] exc_count;

    // Count accepted redirects by type; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= 32'h0;
            exc_count <= 32'h0;
        end else if (accept) begin
            if (sel_exc) begin
                exc_count <= exc_count + 32'd1;
            end else begin
                br_count  <= br_count + 32'd1;
            end
        end
    end

    assign o_branch_redirects = br_count;
    assign o_exc_redirects    = exc_count;
`else
    assign o_branch_redirects = 32'h0;
    assign o_exc_redirects    = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized + directed bench for pc_redirect_unit against a pending-request
// reference model.
module tb_pc_redirect_unit;

    localparam logic [31:0] EXC_VEC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_stall;
    logic        i_br_valid;
    logic        i_br_taken;
    logic [31:0] i_br_target;
    logic        i_exc_req;
    logic        o_load_we;
    logic [31:0] o_load_pc;
    logic        o_flush;
    logic        o_misaligned;
    logic [31:0] o_branch_redirects;
    logic [31:0] o_exc_redirects;

    pc_redirect_unit #(.EXC_VECTOR(EXC_VEC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_stall           (i_stall),
        .i_br_valid        (i_br_valid),
        .i_br_taken        (i_br_taken),
        .i_br_target       (i_br_target),
        .i_exc_req         (i_exc_req),
        .o_load_we         (o_load_we),
        .o_load_pc         (o_load_pc),
        .o_flush           (o_flush),
        .o_misaligned      (o_misaligned),
        .o_branch_redirects(o_branch_redirects),
        .o_exc_redirects   (o_exc_redirects)
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: at most one pending redirect (older one wins)
    bit          pend_valid;
    bit          pend_exc;
    bit          pend_mis;
    logic [31:0] pend_pc;
    logic [31:0] cnt_br;
    logic [31:0] cnt_exc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_valid = 0; pend_exc = 0; pend_mis = 0; pend_pc = 32'h0;
        cnt_br = 32'h0; cnt_exc = 32'h0;
    endtask

    task automatic drive(input bit stall, input bit bv, input bit bt,
                         input logic [31:0] tgt, input bit exc);
        i_stall = stall; i_br_valid = bv; i_br_taken = bt;
        i_br_target = tgt; i_exc_req = exc;
    endtask

    task automatic check_counters(input string tag);
`ifdef REDIRECT_STATS_EN
        check_eq({tag, ".brcnt"}, o_branch_redirects, cnt_br);
        check_eq({tag, ".exccnt"}, o_exc_redirects, cnt_exc);
`else
        check_eq({tag, ".brcnt"}, o_branch_redirects, 32'h0);
        check_eq({tag, ".exccnt"}, o_exc_redirects, 32'h0);
`endif
    endtask

    // Called just after a rising edge with inputs driven; checks at the
    // falling edge, then advances the model across the next rising edge.
    task automatic cycle(input string tag);
        bit          we, is_exc, mis, acc;
        logic [31:0] pc;
        we = 0; is_exc = 0; mis = 0; pc = 32'h0;
        if (i_exc_req) begin
            we = 1; is_exc = 1; pc = EXC_VEC;
        end else if (pend_valid) begin
            we = 1; is_exc = pend_exc; pc = pend_pc; mis = pend_mis;
        end else if (i_br_valid && i_br_taken) begin
            we = 1; pc = i_br_target & 32'hFFFF_FFFC; mis = (i_br_target % 4) != 0;
        end
        acc = we && !i_stall;
        @(negedge clk);
        check_eq({tag, ".we"}, {31'h0, o_load_we}, {31'h0, we});
        check_eq({tag, ".pc"}, o_load_pc, pc);
        check_eq({tag, ".flush"}, {31'h0, o_flush}, {31'h0, acc});
        check_eq({tag, ".mis"}, {31'h0, o_misaligned}, {31'h0, acc && !is_exc && mis});
        check_counters(tag);
        @(posedge clk);
        if (acc) begin
            if (is_exc) cnt_exc = cnt_exc + 1;
            else        cnt_br  = cnt_br + 1;
            pend_valid = 0;
        end else if (we) begin
            pend_valid = 1; pend_exc = is_exc; pend_pc = pc; pend_mis = mis;
        end
        #1;
    endtask

    initial begin
        // reset
        drive(0, 0, 0, 32'h0, 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_eq("rst.we", {31'h0, o_load_we}, 32'h0);
        check_eq("rst.pc", o_load_pc, 32'h0);
        check_eq("rst.flush", {31'h0, o_flush}, 32'h0);
        check_counters("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle("idle0");

        // immediate branch redirect
        drive(0, 1, 1, 32'h40, 0); cycle("br40");
        drive(0, 0, 0, 32'h0, 0);  cycle("br40.after");
        // not-taken branch is not a request
        drive(0, 1, 0, 32'h80, 0); cycle("nottaken");

        // branch held under three stall cycles
        drive(1, 1, 1, 32'h100, 0); cycle("hold100.0");
        drive(1, 0, 0, 32'h0, 0);   cycle("hold100.1");
        drive(1, 1, 1, 32'h300, 0); cycle("hold100.2");
        drive(0, 0, 0, 32'h0, 0);   cycle("hold100.acc");
        drive(0, 0, 0, 32'h0, 0);   cycle("hold100.idle");

        // exception replaces held branch
        drive(1, 1, 1, 32'h100, 0); cycle("rep.0");
        drive(1, 0, 0, 32'h0, 1);   cycle("rep.exc");
        drive(1, 0, 0, 32'h0, 0);   cycle("rep.hold");
        drive(0, 1, 1, 32'h200, 0); cycle("rep.acc");

        // held exception ignores new branch; then misaligned branch
        drive(1, 0, 0, 32'h0, 1);   cycle("hexc.0");
        drive(1, 1, 1, 32'h200, 0); cycle("hexc.br");
        drive(0, 1, 1, 32'h200, 0); cycle("hexc.acc");
        drive(0, 1, 1, 32'h203, 0); cycle("mis203");
        // exception over held branch in the accept cycle
        drive(1, 1, 1, 32'h500, 0); cycle("acc_exc.0");
        drive(0, 0, 0, 32'h0, 1);   cycle("acc_exc.acc");

        // reset during HOLD_BR
        drive(1, 1, 1, 32'h100, 0); cycle("rsthold.0");
        drive(1, 0, 0, 32'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rsthold.we", {31'h0, o_load_we}, 32'h0);
        check_eq("rsthold.pc", o_load_pc, 32'h0);
        model_reset();
        check_counters("rsthold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 0);
        cycle("rsthold.after");

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom, $urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

- Producer side of the load-PC interface: drives the redirect write-enable and new PC consumed by the fetch unit.
- Merges two redirect sources:
  - taken branches/jumps resolved in EX (fetch always predicts fall-through, pc+4);
  - exception requests from MEM, sent to a fixed vector.
- The fetch unit ignores load-PC while stalled, so a redirect arriving during a stall is captured and held until the first unstalled cycle.
- Also drives the IF/ID flush.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0180, exception handler address.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_stall  in  1  hazard-control stall seen by fetch this cycle.
- i_br_valid  in  1  EX has a resolved control-flow instruction.
- i_br_taken  in  1  branch/jump taken (redirect required).
- i_br_target  in  32  taken target.
- i_exc_req  in  1  MEM raises exception.
- o_load_we  out  1  load-PC write enable to fetch.
- o_load_pc  out  32  load-PC new value.
- o_flush  out  1  squash IF/ID; high only in an accept cycle.
- o_misaligned  out  1  accepted branch target had bits[1:0] != 0.
- o_branch_redirects  out  32  count of accepted branch redirects (see Configuration).
- o_exc_redirects  out  32  count of accepted exception redirects (see Configuration).

## Operation
- Incoming request priority: i_exc_req > held request > branch (i_br_valid & i_br_taken).
- A branch with i_br_taken=0 is not a request.
- Outputs are combinational from the winning source, giving zero-latency redirect.
- States:
  - IDLE: no held request.
  - HOLD_BR: holding a branch redirect.
  - HOLD_EXC: holding an exception redirect.
- Accept cycle: o_load_we=1 and i_stall=0. o_flush=1 exactly in that cycle.
- IDLE:
  - Request with i_stall=0: accepted same cycle; stay IDLE.
  - Request with i_stall=1: register PC and type. Exception → HOLD_EXC; branch → HOLD_BR.
- HOLD_BR:
  - o_load_we=1, o_load_pc=held target.
  - i_exc_req replaces the held branch (→ HOLD_EXC, or accepted directly if i_stall=0).
  - New branch requests are ignored; they are younger, squashed instructions.
  - i_stall=0 with no exception: accept, → IDLE.
- HOLD_EXC:
  - o_load_pc=EXC_VECTOR.
  - All new requests are ignored; the older exception wins.
  - i_stall=0: accept, → IDLE.
- Exception PC is always EXC_VECTOR.
- Branch target is forced to {target[31:2],2'b00}. o_misaligned=1 in the accept cycle if the original bits[1:0] != 0.
- Reset values: all outputs 0, state IDLE, held PC 0, counters 0.

## Timing
- Request in cycle N with i_stall=0: o_load_we=1 and o_flush=1 in N; fetch PC equals the redirect target at N+1.
- Request in N with i_stall=1 through cycle M-1, stall low at M:
  - o_load_we=1 with a stable o_load_pc for N..M;
  - o_flush=1 only at M;
  - IDLE at M+1.
- A request arriving in the same cycle a held request is accepted follows the priority rule:
  - exception over held branch: the exception is sent, the branch is dropped;
  - otherwise the new request is ignored.
- Reset asserted mid-HOLD: held request discarded immediately, outputs 0 asynchronously; the first post-reset cycle starts IDLE.
- Counters increment on the clock edge ending an accept cycle, by type of the accepted request; they wrap at 2^32.

## Configuration
- REDIRECT_STATS_EN defined: o_branch_redirects and o_exc_redirects are live 32-bit counters as above.
- Not defined: both ports are present and tied to 32'h0; no counter flops are instantiated.

## Test plan
- Reset with rst_n=0 mid-cycle: all outputs 0 immediately. Release, idle cycle: o_load_we=0.
- Branch taken, target 0x0000_0040, i_stall=0 → same cycle o_load_we=1, o_load_pc=0x40, o_flush=1; next cycle IDLE, outputs 0.
- Branch taken, target 0x100, i_stall=1 for 3 cycles then 0 → o_load_pc=0x100 held 4 cycles; o_flush only in the 4th; branch counter +1.
- Held branch 0x100 under stall, i_exc_req pulses → o_load_pc switches to 0x180; on unstall exception counter +1, branch counter unchanged.
- Held exception, new taken branch 0x200 arrives → ignored; 0x180 accepted. Target 0x203 accepted → o_load_pc=0x200, o_misaligned=1.
- rst_n asserted during HOLD_BR → o_load_we drops asynchronously; after release no redirect is issued.
